// File: rtl/logic_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package logic_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level subtractor cells: a half subtractor and a full subtractor
// built from two of them, with the two borrows ORed together.
module half_subtractor (
  input  logic Xi,
  input  logic Yi,
  output logic Di,
  output logic Bo
);
  assign Di = Xi ^ Yi;
  assign Bo = ~Xi & Yi;
endmodule

module full_subtractor (
  input  logic Xi,
  input  logic Yi,
  input  logic Bi,
  output logic Di,
  output logic Bi1
);
  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs0 (
    .Xi (Xi),
    .Yi (Yi),
    .Di (w_d1),
    .Bo (w_b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs1 (
    .Xi (w_d1),
    .Yi (Bi),
    .Di (Di),
    .Bo (w_b2)
  );

  assign Bi1 = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - BIN, LSB first, one bit per clock,
// with a start/busy/done handshake and a single registered borrow.
module serial_subtractor
  import logic_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_subtractor u_fs (
    .Xi  (r_sha[0]),
    .Yi  (r_shb[0]),
    .Bi  (r_br),
    .Di  (w_d),
    .Bi1 (w_bo)
  );

  // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      D       <= '0;
      BOUT    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            r_sha   <= A;
            r_shb   <= B;
            r_br    <= BIN;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_state <= RUN;
          end else begin
            BUSY    <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_res <= w_res_next;
          r_sha <= r_sha >> 1;
          r_shb <= r_shb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            D       <= w_res_next;
            BOUT    <= w_bo;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            r_state <= FIN;
          end
        end
        default: begin
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the 8-bit serial subtractor: handshake timing,
// borrow edge cases, ignored START, back-to-back operation and async reset.
module tb_serial_subtractor;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BIN;
  logic       BUSY;
  logic       DONE;
  logic [7:0] D;
  logic       BOUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_d;
  logic       last_bout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs [7];

  serial_subtractor #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
    .BOUT  (BOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation from START to the cycle after DONE.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] exp_d, input logic exp_bout, input string name);
    int   nbusy;
    logic done_early;
    A = a; B = b; BIN = bin; START = 1'b1;
    tick();
    START = 1'b0;
    A = 8'($urandom); B = 8'($urandom); BIN = 1'($urandom);
    nbusy = 0;
    done_early = 1'b0;
    while (BUSY && nbusy < 20) begin
      if (DONE) done_early = 1'b1;
      if (D !== last_d) done_early = 1'b1;
      nbusy++;
      tick();
    end
    chk({name, " busy_cycles"}, 32'(nbusy), 32'd8);
    chk({name, " no_done_or_D_change_while_busy"}, 32'(done_early), 32'd0);
    chk({name, " done"}, 32'(DONE), 32'd1);
    chk({name, " D"}, 32'(D), 32'(exp_d));
    chk({name, " BOUT"}, 32'(BOUT), 32'(exp_bout));
    last_d = exp_d;
    last_bout = exp_bout;
    tick();
    chk({name, " done_one_cycle"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int          ndone;
    logic [7:0]  cap_d;
    logic        stable_ok;
    logic [8:0]  ref9;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rbin;

    vecs[0] = '{8'd100, 8'd58,  1'b0, 8'd42,  1'b0};
    vecs[1] = '{8'd5,   8'd7,   1'b0, 8'hFE,  1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00,  1'b0};
    vecs[4] = '{8'h00,  8'hFF,  1'b0, 8'h01,  1'b1};
    vecs[5] = '{8'h80,  8'h01,  1'b1, 8'h7E,  1'b0};
    vecs[6] = '{8'hFF,  8'h00,  1'b1, 8'hFE,  1'b0};

    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
    last_d = '0; last_bout = 1'b0;
    tick(); tick();
    chk("reset BUSY", 32'(BUSY), 32'd0);
    chk("reset DONE", 32'(DONE), 32'd0);
    chk("reset D", 32'(D), 32'd0);
    chk("reset BOUT", 32'(BOUT), 32'd0);
    RST_N = 1'b1;
    tick();
    chk("idle no busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout, $sformatf("vec%0d", i));

    // START during RUN must be ignored.
    A = 8'd100; B = 8'd58; BIN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick();
    A = 8'd1; B = 8'd1; START = 1'b1;
    tick();
    START = 1'b0;
    ndone = 0;
    cap_d = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      if (DONE) begin ndone++; cap_d = D; end
      tick();
    end
    chk("ignore_start done_count", 32'(ndone), 32'd1);
    chk("ignore_start D", 32'(cap_d), 32'd42);
    last_d = 8'd42; last_bout = 1'b0;

    // START held high: back-to-back operations every 9 cycles.
    START = 1'b1;
    for (int op = 0; op < 4; op++) begin
      A = vecs[op + 1].a; B = vecs[op + 1].b; BIN = vecs[op + 1].bin;
      tick();
      stable_ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (DONE !== 1'b0 || BUSY !== 1'b1 || D !== last_d) stable_ok = 1'b0;
        tick();
      end
      chk($sformatf("held op%0d stable", op), 32'(stable_ok), 32'd1);
      chk($sformatf("held op%0d done", op), 32'(DONE), 32'd1);
      chk($sformatf("held op%0d D", op), 32'(D), 32'(vecs[op + 1].d));
      chk($sformatf("held op%0d BOUT", op), 32'(BOUT), 32'(vecs[op + 1].bout));
      last_d = vecs[op + 1].d;
      last_bout = vecs[op + 1].bout;
      if (op == 3) START = 1'b0;
    end
    tick();
    chk("held end idle", 32'(BUSY | DONE), 32'd0);

    // Asynchronous reset mid-RUN.
    do_op(8'd5, 8'd7, 1'b0, 8'hFE, 1'b1, "pre_reset");
    A = 8'd100; B = 8'd58; BIN = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst BUSY", 32'(BUSY), 32'd0);
    chk("async_rst DONE", 32'(DONE), 32'd0);
    chk("async_rst D", 32'(D), 32'd0);
    chk("async_rst BOUT", 32'(BOUT), 32'd0);
    tick();
    RST_N = 1'b1;
    last_d = '0; last_bout = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (DONE || BUSY) ndone++;
      tick();
    end
    chk("post_reset no activity", 32'(ndone), 32'd0);
    do_op(8'd100, 8'd58, 1'b0, 8'd42, 1'b0, "post_reset op");

    // Random sweep against an independent 9-bit reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      if (i % 50 == 0) ra = 8'h00;
      if (i % 50 == 1) rb = 8'hFF;
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      do_op(ra, rb, rbin, ref9[7:0], ref9[8], $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
